rom_dl_sdram_writer: RTL and testbench

- Sits between the HPS ioctl download stream and the dual-port SDRAM controller in the clk_mem domain.
- Buffers incoming ROM bytes in a small FIFO and decodes each byte's region.
- Issues toggle-handshake writes on SDRAM port1 (CPU/sound ROMs) and port2 (sprite ROMs, address-remapped to 32-bit words).
- Asserts ioctl_wait as back-pressure and flags download completion once every write has been acknowledged.

---
 rtl/rom_dl_sdram_writer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_rom_dl_sdram_writer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_sdram_writer.sv
// ROM download writer: buffers HPS ioctl bytes in a small FIFO and writes them to
// SDRAM port1 (CPU/sound) or port2 (sprites). Optional feature macro: DL_CHECKSUM_EN.
module rom_dl_sdram_writer #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [24:0] P1_LIMIT   = 25'h10000,
  parameter logic [24:0] SP_BASE    = 25'h10000,
  parameter logic [24:0] SP_SIZE    = 25'h0C000,
  parameter logic [7:0]  ROM_INDEX  = 8'd0
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        dl_done
`ifdef DL_CHECKSUM_EN
  ,
  output logic [15:0] dl_sum,
  output logic        dl_overflow
`endif
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_FULL = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] CNT_WAIT = CNT_FULL - CNT_ONE - CNT_ONE;
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [25:0] SP_END   = {1'b0, SP_BASE} + {1'b0, SP_SIZE};
  localparam logic [23:0] SP_BASE_LO = SP_BASE[23:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [32:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [AW:0]     w_count_nxt;
  logic            r_wait;
  logic            r_accepted;
  logic            r_dl_done;
  logic            r_hit1;
  logic            r_hit2;
  logic            r_p1_req;
  logic            r_p2_req;
  logic [22:0]     r_p1_a;
  logic [1:0]      r_p1_ds;
  logic [15:0]     r_p1_d;
  logic [22:0]     r_p2_a;
  logic [1:0]      r_p2_ds;
  logic [15:0]     r_p2_d;

  logic [32:0]     w_head;
  logic [24:0]     w_addr;
  logic [7:0]      w_data;
  logic [23:0]     w_off;
  logic            w_hit1;
  logic            w_hit2;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_load;
  logic            w_full;
  logic            w_acks_done;
  logic            w_done_cond;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_addr     = w_head[32:8];
  assign w_data     = w_head[7:0];
  assign w_off      = w_addr[23:0] - SP_BASE_LO;
  assign w_hit1     = (w_addr < P1_LIMIT);
  assign w_hit2     = (w_addr >= SP_BASE) && ({1'b0, w_addr} < SP_END);
  assign w_full     = (r_count == CNT_FULL);
  assign w_push_req = ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX);
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign w_push     = w_push_req && (!w_full || w_pop);
  // An ack equal to the pre-toggle req value reads as still pending
  assign w_acks_done = (!r_hit1 || (port1_ack == r_p1_req)) &&
                       (!r_hit2 || (port2_ack == r_p2_req));
  assign w_done_cond = !ioctl_download && (r_count == CNT_ZERO) &&
                       (r_state == S_IDLE) && r_accepted;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {ioctl_addr, ioctl_dout};
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= CNT_ZERO;
      r_wait     <= 1'b0;
      r_accepted <= 1'b0;
      r_dl_done  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count   <= w_count_nxt;
      r_wait    <= (w_count_nxt >= CNT_WAIT);
      r_dl_done <= w_done_cond;
      if (w_push) begin
        r_accepted <= 1'b1;
      end else if (w_done_cond) begin
        r_accepted <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_count != CNT_ZERO) w_state_nxt = S_LOAD;
        else                     w_state_nxt = S_IDLE;
      end
      S_LOAD: begin
        if (w_hit1 || w_hit2) w_state_nxt = S_WAIT;
        else                  w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (w_acks_done) w_state_nxt = S_IDLE;
        else             w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_pop  = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_load = 1'b1;
        w_pop  = !w_hit1 && !w_hit2;
      end
      S_WAIT: begin
        w_load = 1'b0;
        w_pop  = w_acks_done;
      end
      default: begin
        w_load = 1'b0;
        w_pop  = 1'b0;
      end
    endcase
  end

  // Sprite words are remapped so each 32-bit word lands on consecutive 16-bit halves
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_hit1   <= 1'b0;
      r_hit2   <= 1'b0;
      r_p1_req <= 1'b0;
      r_p2_req <= 1'b0;
      r_p1_a   <= 23'd0;
      r_p1_ds  <= 2'b00;
      r_p1_d   <= 16'd0;
      r_p2_a   <= 23'd0;
      r_p2_ds  <= 2'b00;
      r_p2_d   <= 16'd0;
    end else if (w_load) begin
      r_hit1 <= w_hit1;
      r_hit2 <= w_hit2;
      if (w_hit1) begin
        r_p1_req <= ~r_p1_req;
        r_p1_a   <= w_addr[23:1];
        r_p1_ds  <= {w_addr[0], ~w_addr[0]};
        r_p1_d   <= {w_data, w_data};
      end
      if (w_hit2) begin
        r_p2_req <= ~r_p2_req;
        r_p2_a   <= {w_off[23:16], w_off[13:0], w_off[15]};
        r_p2_ds  <= {w_off[14], ~w_off[14]};
        r_p2_d   <= {w_data, w_data};
      end
    end
  end

  assign ioctl_wait = r_wait;
  assign port1_req  = r_p1_req;
  assign port1_a    = r_p1_a;
  assign port1_ds   = r_p1_ds;
  assign port1_d    = r_p1_d;
  assign port2_req  = r_p2_req;
  assign port2_a    = r_p2_a;
  assign port2_ds   = r_p2_ds;
  assign port2_d    = r_p2_d;
  assign dl_done    = r_dl_done;

`ifdef DL_CHECKSUM_EN
  logic        r_dl_q;
  logic [15:0] r_sum;
  logic        r_overflow;
  logic        w_dl_rise;

  assign w_dl_rise = ioctl_download && !r_dl_q;

  // Sum restarts on each new download; a byte accepted on the rising cycle seeds it
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_dl_q     <= 1'b0;
      r_sum      <= 16'd0;
      r_overflow <= 1'b0;
    end else begin
      r_dl_q <= ioctl_download;
      if (w_dl_rise) begin
        r_sum <= w_push ? {8'h00, ioctl_dout} : 16'd0;
      end else if (w_push) begin
        r_sum <= r_sum + {8'h00, ioctl_dout};
      end
      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign dl_sum      = r_sum;
  assign dl_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_rom_dl_sdram_writer.sv
// Self-checking bench for rom_dl_sdram_writer: directed steps plus randomized bytes
// checked against a queue model of the expected SDRAM writes.
module tb_rom_dl_sdram_writer;

  localparam int unsigned P1_LIM  = 32'h10000;
  localparam int unsigned SP_LO   = 32'h10000;
  localparam int unsigned SP_HI   = 32'h1C000;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req;
  logic        port2_ack;
  logic [22:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        dl_done;
`ifdef DL_CHECKSUM_EN
  logic [15:0] dl_sum;
  logic        dl_overflow;
`endif

  rom_dl_sdram_writer dut (
    .clk            (clk),
    .RST_N          (RST_N),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .port1_req      (port1_req),
    .port1_ack      (port1_ack),
    .port1_a        (port1_a),
    .port1_ds       (port1_ds),
    .port1_d        (port1_d),
    .port2_req      (port2_req),
    .port2_ack      (port2_ack),
    .port2_a        (port2_a),
    .port2_ds       (port2_ds),
    .port2_d        (port2_d),
    .dl_done        (dl_done)
`ifdef DL_CHECKSUM_EN
    ,
    .dl_sum         (dl_sum),
    .dl_overflow    (dl_overflow)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          tog_cyc = 0;
  int          push_cyc = 0;
  int          dl_done_cnt = 0;
  int          exp_done = 0;
  bit          hold_ack = 1'b0;
  logic        prev1 = 1'b0;
  logic        prev2 = 1'b0;
  int          dly1 = 0;
  int          dly2 = 0;
  logic [42:0] obs_q[$];
  logic [42:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe request toggles and completion pulses
  always @(negedge clk) begin
    if (!RST_N) begin
      prev1 = port1_req;
      prev2 = port2_req;
    end else begin
      if (port1_req != prev1) begin
        obs_q.push_back({2'd1, port1_a, port1_ds, port1_d});
        tog_cyc = cyc;
      end
      if (port2_req != prev2) begin
        obs_q.push_back({2'd2, port2_a, port2_ds, port2_d});
        tog_cyc = cyc;
      end
      prev1 = port1_req;
      prev2 = port2_req;
      if (dl_done) dl_done_cnt++;
    end
  end

  // SDRAM side: return each ack two cycles after its request toggles
  always @(negedge clk) begin
    if (!RST_N) begin
      port1_ack = 1'b0;
      port2_ack = 1'b0;
      dly1 = 0;
      dly2 = 0;
    end else if (hold_ack) begin
      dly1 = 0;
      dly2 = 0;
    end else begin
      if (port1_req != port1_ack) begin
        dly1++;
        if (dly1 >= 2) begin port1_ack = port1_req; dly1 = 0; end
      end
      if (port2_req != port2_ack) begin
        dly2++;
        if (dly2 >= 2) begin port2_ack = port2_req; dly2 = 0; end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected writes derived directly from the address map arithmetic
  function automatic void model_add(input logic [24:0] a, input logic [7:0] d);
    int unsigned ai;
    int unsigned off;
    int unsigned pa;
    logic [1:0]  ds;
    ai = 32'(a);
    if (ai < P1_LIM) begin
      ds = (ai % 2 == 1) ? 2'b10 : 2'b01;
      exp_q.push_back({2'd1, 23'(ai / 2), ds, d, d});
    end
    if (ai >= SP_LO && ai < SP_HI) begin
      off = ai - SP_LO;
      pa  = (off / 65536) * 32768 + (off % 16384) * 2 + (off / 32768) % 2;
      ds  = (((off / 16384) % 2) == 1) ? 2'b10 : 2'b01;
      exp_q.push_back({2'd2, 23'(pa), ds, d, d});
    end
  endfunction

  task automatic push(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx,
                      input bit honour, input bit accept);
    int guard;
    guard = 0;
    @(negedge clk);
    while (honour && ioctl_wait && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("wait_timeout", 64'(ioctl_wait), 64'd0);
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_index = idx;
    ioctl_wr    = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    push_cyc = cyc;
    if (accept && ioctl_download && idx == 8'd0) model_add(a, d);
  endtask

  task automatic wait_done(input string tag);
    exp_done++;
    for (int i = 0; i < 400; i++) begin
      if (dl_done_cnt >= exp_done) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check(tag, 64'(dl_done_cnt), 64'(exp_done));
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_n"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int pushed;
    int stall;
    logic [24:0] ra;
    logic [7:0]  ri;

    RST_N = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = 25'd0;
    ioctl_dout = 8'd0;
    ioctl_index = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({port1_req, port2_req, ioctl_wait, dl_done, port1_a, port1_ds,
                             port2_a, port2_ds}), 64'd0);
    check("reset_data", 64'({port1_d, port2_d}), 64'd0);
`ifdef DL_CHECKSUM_EN
    check("reset_sum", 64'({dl_sum, dl_overflow}), 64'd0);
`endif
    RST_N = 1'b1;
    repeat (2) @(negedge clk);

    // single port1 byte
    ioctl_download = 1'b1;
    push(25'h00003, 8'hA5, 8'd0, 1'b0, 1'b1);
    ioctl_download = 1'b0;
    wait_done("t1_done");
    check("t1_latency", 64'(tog_cyc), 64'(push_cyc + 2));
    check("t1_fields", (obs_q.size() > 0) ? 64'(obs_q[0]) : 64'd0,
          64'({2'd1, 23'h1, 2'b10, 16'hA5A5}));
    check_writes("t1");

    // single sprite byte
    ioctl_download = 1'b1;
    push(25'h14001, 8'h3C, 8'd0, 1'b0, 1'b1);
    ioctl_download = 1'b0;
    wait_done("t2_done");
    check("t2_fields", (obs_q.size() > 0) ? 64'(obs_q[0]) : 64'd0,
          64'({2'd2, 23'h2, 2'b10, 16'h3C3C}));
    check_writes("t2");

    // foreign index is ignored
    ioctl_download = 1'b1;
    for (int k = 0; k < 3; k++) push(25'h00010 + 25'(k), 8'h11, 8'd254, 1'b0, 1'b1);
    ioctl_download = 1'b0;
    repeat (20) @(negedge clk);
    check("idx_no_write", 64'(obs_q.size()), 64'd0);
    check("idx_no_done", 64'(dl_done_cnt), 64'(exp_done));

    // burst with acks held off, HPS honouring wait
    hold_ack = 1'b1;
    ioctl_download = 1'b1;
    pushed = 0;
    stall = 0;
    for (int cy = 0; cy < 400 && pushed < 10; cy++) begin
      @(negedge clk);
      if (ioctl_wr) begin
        pushed++;
        model_add(ioctl_addr, ioctl_dout);
      end
      ioctl_wr = 1'b0;
      if (hold_ack) begin
        check("burst_wait", 64'(ioctl_wait), 64'(pushed >= 6));
        if (ioctl_wait) stall++;
        if (stall == 4) hold_ack = 1'b0;
      end
      if (!ioctl_wait && pushed < 10) begin
        ioctl_addr  = (pushed < 5) ? 25'h00100 + 25'(pushed) : 25'h12000 + 25'(pushed);
        ioctl_dout  = 8'($urandom);
        ioctl_index = 8'd0;
        ioctl_wr    = 1'b1;
      end
    end
    check("burst_pushed", 64'(pushed), 64'd10);
    hold_ack = 1'b0;
    ioctl_download = 1'b0;
    wait_done("burst_done");
    check_writes("burst");

    // reset while a port1 write is outstanding
    hold_ack = 1'b1;
    ioctl_download = 1'b1;
    push(25'h00020, 8'h77, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 50 && obs_q.size() == 0; i++) @(negedge clk);
    check_writes("pre_rst");
    @(negedge clk);
    RST_N = 1'b0;
    #1;
    check("rst_outs", 64'({port1_req, port2_req, ioctl_wait, dl_done, port1_a, port1_ds,
                           port2_a, port2_ds}), 64'd0);
    check("rst_data", 64'({port1_d, port2_d}), 64'd0);
    repeat (2) @(negedge clk);
    RST_N = 1'b1;
    hold_ack = 1'b0;
    push(25'h00041, 8'h5A, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 50 && obs_q.size() == 0; i++) @(negedge clk);
    check("rst_req_rise", 64'(port1_req), 64'd1);
    ioctl_download = 1'b0;
    wait_done("rst_done");
    check_writes("post_rst");

    // randomized bytes across all regions and indices
    ioctl_download = 1'b1;
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 2))
        0:       ra = 25'($urandom_range(0, 32'hFFFF));
        1:       ra = 25'h10000 + 25'($urandom_range(0, 32'hBFFF));
        default: ra = 25'h1C000 + 25'($urandom_range(0, 32'h3FFF));
      endcase
      ri = ($urandom_range(0, 7) == 0) ? 8'd254 : 8'd0;
      push(ra, 8'($urandom), ri, 1'b1, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    ioctl_download = 1'b0;
    wait_done("rand_done");
    check_writes("rand");

`ifdef DL_CHECKSUM_EN
    ioctl_download = 1'b1;
    push(25'h00200, 8'hFF, 8'd0, 1'b0, 1'b1);
    push(25'h00201, 8'h02, 8'd0, 1'b0, 1'b1);
    push(25'h00202, 8'h10, 8'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("sum", 64'(dl_sum), 64'h0111);
    ioctl_download = 1'b0;
    wait_done("sum_done");
    check_writes("sum");
    check("ovf_clear", 64'(dl_overflow), 64'd0);

    hold_ack = 1'b1;
    ioctl_download = 1'b1;
    for (int k = 0; k < 9; k++) push(25'h00300 + 25'(k), 8'(k + 1), 8'd0, 1'b0, k < 8);
    @(negedge clk);
    check("ovf_set", 64'(dl_overflow), 64'd1);
    hold_ack = 1'b0;
    ioctl_download = 1'b0;
    wait_done("ovf_done");
    check_writes("ovf");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
